// File: rtl/sum_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module   : sum_accumulator_if
// Purpose  : Operand stream, burst control and external-adder bus for
//            sum_accumulator.
// Revision : 1.0 - initial release
// ============================================================================
interface sum_accumulator_if #(
  parameter int NUMBITS = 16,
  parameter int CNTBITS = 8
);
  logic               start;
  logic [CNTBITS-1:0] burst_len;
  logic               in_valid;
  logic               in_ready;
  logic [NUMBITS-1:0] in_data;
  logic [NUMBITS-1:0] add_a;
  logic [NUMBITS-1:0] add_b;
  logic               add_cin;
  logic [NUMBITS-1:0] add_result;
  logic               add_cout;
  logic [NUMBITS-1:0] sum;
  logic               overflow;
  logic               busy;
  logic               done;

  // Control, operand and adder-return side (stimulus source plus the adder).
  modport master (
    output start, burst_len, in_valid, in_data, add_result, add_cout,
    input  in_ready, add_a, add_b, add_cin, sum, overflow, busy, done
  );

  // The accumulator itself.
  modport slave (
    input  start, burst_len, in_valid, in_data, add_result, add_cout,
    output in_ready, add_a, add_b, add_cin, sum, overflow, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/sum_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : sum_accumulator
// Purpose  : Burst accumulator around an external combinational adder.
//            Optional macro ACCUM_SATURATE_EN clamps the sum to all-ones on carry.
// Revision : 1.0 - initial release
// ============================================================================
module sum_accumulator #(
  parameter int NUMBITS = 16,
  parameter int CNTBITS = 8
) (
  input  logic             clk,
  input  logic             rst,
  sum_accumulator_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [NUMBITS-1:0] r_sum;
  logic [NUMBITS-1:0] w_sum_beat;
  logic               r_overflow;
  logic [CNTBITS-1:0] r_remaining;
  logic               w_in_ready;
  logic               w_beat;
  logic               w_start_burst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_next = (bus.burst_len == '0) ? S_DONE : S_ACCUM;
        end
      end
      S_ACCUM: begin
        w_in_ready = 1'b1;
        if (bus.in_valid && (r_remaining == CNTBITS'(1))) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign w_beat        = w_in_ready & bus.in_valid;
  assign w_start_burst = (r_state == S_IDLE) & bus.start;

`ifdef ACCUM_SATURATE_EN
  // Clamp on carry; later beats add normally from the clamped value.
  assign w_sum_beat = bus.add_cout ? {NUMBITS{1'b1}} : bus.add_result;
`else
  assign w_sum_beat = bus.add_result;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum       <= '0;
      r_overflow  <= 1'b0;
      r_remaining <= '0;
    end else if (w_start_burst) begin
      r_sum       <= '0;
      r_overflow  <= 1'b0;
      r_remaining <= bus.burst_len;
    end else if (w_beat) begin
      r_sum       <= w_sum_beat;
      r_overflow  <= r_overflow | bus.add_cout;
      r_remaining <= r_remaining - CNTBITS'(1);
    end
  end

  assign bus.add_a    = r_sum;
  assign bus.add_b    = bus.in_data;
  assign bus.add_cin  = 1'b0;
  assign bus.sum      = r_sum;
  assign bus.overflow = r_overflow;
  assign bus.in_ready = w_in_ready;
  assign bus.busy     = (r_state == S_ACCUM) || (r_state == S_DONE);
  assign bus.done     = (r_state == S_DONE);

endmodule
`default_nettype wire
